regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester writeback arbiter for a 32x32 register file.
// Each requester (0 = ALU, 1 = LSU) owns a one-entry holding buffer. Both buffers full
// with different addresses alternate round-robin; with the same address the older entry
// is written first. Handshakes to register 0 are accepted and dropped.
// Optional build macro WB_BYPASS_EN adds two read-bypass ports that search the buffers.
module regfile_wb_arbiter #(
    parameter int ADSize = 5,
    parameter int DASize = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADSize-1:0] req0_addr,
    input  logic [DASize-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADSize-1:0] req1_addr,
    input  logic [DASize-1:0] req1_data,
    output logic              rf_write,
    output logic [ADSize-1:0] rf_waddr,
    output logic [DASize-1:0] rf_din,
    output logic              grant_id
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADSize-1:0] byp_addr1,
    input  logic [ADSize-1:0] byp_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DASize-1:0] byp_data1,
    output logic [DASize-1:0] byp_data2
`endif
);

    logic              full0, full1;
    logic [ADSize-1:0] addr0, addr1;
    logic [DASize-1:0] data0, data1;
    logic              last_grant;  // requester granted most recently
    logic              age;         // 0: buffer 0 holds the older entry, 1: buffer 1 does

    logic grant_valid, grant_sel, grant0, grant1;
    logic hs0, hs1, load0, load1;

    // Grant selection: age decides same-address conflicts, round-robin otherwise.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (!rst && enable) begin
            if (full0 && full1) begin
                grant_valid = 1'b1;
                grant_sel   = (addr0 == addr1) ? age : ~last_grant;
            end else if (full0) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (full1) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    assign grant0 = grant_valid && !grant_sel;
    assign grant1 = grant_valid && grant_sel;

    // Ready is forced high during reset since the held entries are about to be discarded.
    assign req0_ready = rst || !full0 || grant0;
    assign req1_ready = rst || !full1 || grant1;

    assign hs0   = req0_valid && req0_ready;
    assign hs1   = req1_valid && req1_ready;
    assign load0 = hs0 && (req0_addr != '0);
    assign load1 = hs1 && (req1_addr != '0);

    // Register-file write port driven straight from the granted buffer.
    always_comb begin
        rf_write = grant_valid;
        grant_id = grant1;
        rf_waddr = '0;
        rf_din   = '0;
        if (grant0) begin
            rf_waddr = addr0;
            rf_din   = data0;
        end else if (grant1) begin
            rf_waddr = addr1;
            rf_din   = data1;
        end
    end

    // Buffer load/clear, round-robin pointer and age tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            full0      <= 1'b0;
            full1      <= 1'b0;
            addr0      <= '0;
            addr1      <= '0;
            data0      <= '0;
            data1      <= '0;
            last_grant <= 1'b1;
            age        <= 1'b0;
        end else begin
            // A reload at the grant edge wins over the clear; address 0 leaves the buffer empty.
            if (hs0) begin
                full0 <= load0;
                if (load0) begin
                    addr0 <= req0_addr;
                    data0 <= req0_data;
                end
            end else if (grant0) begin
                full0 <= 1'b0;
            end
            if (hs1) begin
                full1 <= load1;
                if (load1) begin
                    addr1 <= req1_addr;
                    data1 <= req1_data;
                end
            end else if (grant1) begin
                full1 <= 1'b0;
            end
            if (grant_valid) begin
                last_grant <= grant1;
            end
            // Whichever buffer did not just load is the older one; a tie favours requester 0.
            if (load0 && load1) begin
                age <= 1'b0;
            end else if (load0) begin
                age <= 1'b1;
            end else if (load1) begin
                age <= 1'b0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // {hit, data} for one bypass lookup; the younger entry wins when both buffers match.
    function automatic logic [DASize:0] lookup(input logic [ADSize-1:0] a);
        logic m0, m1;
        m0 = full0 && (addr0 == a) && (a != '0);
        m1 = full1 && (addr1 == a) && (a != '0);
        if (m0 && m1) begin
            lookup = {1'b1, age ? data0 : data1};
        end else if (m0) begin
            lookup = {1'b1, data0};
        end else if (m1) begin
            lookup = {1'b1, data1};
        end else begin
            lookup = '0;
        end
    endfunction

    // Bypass search over the holding buffers for both read ports.
    always_comb begin
        {byp_hit1, byp_data1} = lookup(byp_addr1);
        {byp_hit2, byp_data2} = lookup(byp_addr2);
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table plus hand-written sequences
// for same-address ordering and reset while entries are held.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_addr, req1_addr, rf_waddr;
    logic [31:0] req0_data, req1_data, rf_din;
    logic        rf_write, grant_id;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_addr1 = '0, byp_addr2 = '0;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ADSize(5), .DASize(32)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_din(rf_din), .grant_id(grant_id)
`ifdef WB_BYPASS_EN
        , .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
    );

    typedef struct {
        logic v0; logic [4:0] a0; logic [31:0] d0;
        logic v1; logic [4:0] a1; logic [31:0] d1;
        logic en;
        logic w; logic [4:0] wa; logic [31:0] din; logic gid; logic r0; logic r1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic [4:0] a1, logic [31:0] d1, logic en,
                                logic w, logic [4:0] wa, logic [31:0] din,
                                logic gid, logic r0, logic r1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.en = en;
        v.w = w; v.wa = wa; v.din = din; v.gid = gid; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic w, input logic [4:0] wa,
                              input logic [31:0] din, input logic gid,
                              input logic r0, input logic r1);
        chk({tag, " rf_write"},   {31'b0, rf_write},   {31'b0, w});
        chk({tag, " rf_waddr"},   {27'b0, rf_waddr},   {27'b0, wa});
        chk({tag, " rf_din"},     rf_din,              din);
        chk({tag, " grant_id"},   {31'b0, grant_id},   {31'b0, gid});
        chk({tag, " req0_ready"}, {31'b0, req0_ready}, {31'b0, r0});
        chk({tag, " req1_ready"}, {31'b0, req1_ready}, {31'b0, r1});
    endtask

    task automatic apply(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic en);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        enable = en;
    endtask

    task automatic idle(input logic en);
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, en);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Sequence: reset, idle, 3+3 contended entries, 4 back-to-back, addr 0, enable low.
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,1,32'h101,    1,9,32'h201,   1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,2,32'h102,    1,10,32'h202,  1, 1,1,32'h101,0,1,0));
        tbl.push_back(mk(1,3,32'h103,    1,10,32'h202,  1, 1,9,32'h201,1,0,1));
        tbl.push_back(mk(1,3,32'h103,    1,11,32'h203,  1, 1,2,32'h102,0,1,0));
        tbl.push_back(mk(0,0,0,          1,11,32'h203,  1, 1,10,32'h202,1,0,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 1,3,32'h103,0,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 1,11,32'h203,1,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,5,32'hA5A5A5A5, 0,0,0,       1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,6,32'h1,      0,0,0,         1, 1,5,32'hA5A5A5A5,0,1,1));
        tbl.push_back(mk(1,7,32'h2,      0,0,0,         1, 1,6,32'h1,0,1,1));
        tbl.push_back(mk(1,8,32'h3,      0,0,0,         1, 1,7,32'h2,0,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 1,8,32'h3,0,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,0,32'hFFFFFFFF, 0,0,0,       1, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 0,0,0,0,1,1));
        tbl.push_back(mk(1,4,32'h44,     0,0,0,         0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,          1,12,32'h55,   0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,          0,0,0,         0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 1,12,32'h55,1,0,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 1,4,32'h44,0,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,         1, 0,0,0,0,1,1));

        rst = 1'b1;
        idle(1'b1);
        @(negedge clk);
        @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 1, 1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].en);
            #1;
            check_outs($sformatf("row%0d", i), tbl[i].w, tbl[i].wa, tbl[i].din,
                       tbl[i].gid, tbl[i].r0, tbl[i].r1);
            @(negedge clk);
        end

        // Make requester 1 the last one granted so round-robin alone would pick requester 0.
        apply(0, 0, 0, 1, 13, 32'h77, 1); #1;
        check_outs("pre1", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        idle(1'b1); #1;
        check_outs("pre2", 1, 13, 32'h77, 1, 1, 1);
        @(negedge clk);

        // Same address: requester 1 loads one edge before requester 0, so it is older.
        apply(0, 0, 0, 1, 7, 32'h11, 0); #1;
        check_outs("age1", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        apply(1, 7, 32'h22, 0, 0, 0, 0); #1;
        check_outs("age2", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        idle(1'b0);
`ifdef WB_BYPASS_EN
        byp_addr1 = 5'd7;
        byp_addr2 = 5'd3;
`endif
        #1;
        check_outs("age3", 0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
        chk("byp_hit1",  {31'b0, byp_hit1}, 32'h1);
        chk("byp_data1", byp_data1, 32'h22);
        chk("byp_hit2",  {31'b0, byp_hit2}, 32'h0);
        chk("byp_data2", byp_data2, 32'h0);
`endif
        @(negedge clk);
        idle(1'b1); #1;
        check_outs("age4", 1, 7, 32'h11, 1, 0, 1);
        @(negedge clk);
        idle(1'b1); #1;
        check_outs("age5", 1, 7, 32'h22, 0, 1, 1);
        @(negedge clk);
        idle(1'b1); #1;
        check_outs("age6", 0, 0, 0, 0, 1, 1);
        @(negedge clk);

        // Fill both buffers with enable low, hold three cycles, then reset them away.
        apply(1, 20, 32'hAA, 1, 21, 32'hBB, 0); #1;
        check_outs("hold0", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        for (int unsigned k = 1; k <= 3; k++) begin
            idle(1'b0); #1;
            check_outs($sformatf("hold%0d", k), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        idle(1'b1); #1;
        check_outs("midrst", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned k = 1; k <= 2; k++) begin
            idle(1'b1); #1;
            check_outs($sformatf("postrst%0d", k), 0, 0, 0, 0, 1, 1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
